usb_rx_drain: RTL and testbench

//  Consumer stage directly downstream of the USB receiver. Pops received bytes from the

---
 rtl/usb_pkg.sv | 38 +++
 rtl/usb_rx_drain.sv | 119 +++++++++++
 tb/tb_usb_rx_drain.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - USB receive-side packet types, PID encodings and PID decode helper
package usb_pkg;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        OUT   = 3'd1,
        IN    = 3'd2,
        DATA0 = 3'd3,
        DATA1 = 3'd4,
        ACK   = 3'd5,
        NAK   = 3'd6,
        STALL = 3'd7
    } rx_pkt_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    function automatic rx_pkt_t pid_to_pkt(input logic [3:0] pid);
        rx_pkt_t pkt;
        case (pid)
            PID_OUT:   pkt = OUT;
            PID_IN:    pkt = IN;
            PID_DATA0: pkt = DATA0;
            PID_DATA1: pkt = DATA1;
            PID_ACK:   pkt = ACK;
            PID_NAK:   pkt = NAK;
            PID_STALL: pkt = STALL;
            default:   pkt = NONE;
        endcase
        return pkt;
    endfunction

endpackage

// File: rtl/usb_rx_drain.sv
// rtl/usb_rx_drain.sv - drains USB RX FIFO into AHB buffer, tracks packet type, size and errors
module usb_rx_drain
    import usb_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             empty,
    input  logic [7:0]       r_data,
    input  logic             rcving,
    input  logic             r_error,
    input  logic [3:0]       PID,
    output logic             r_enable,
    output logic [7:0]       buf_wdata,
    output logic             buf_wvalid,
    input  logic             buf_wready,
    input  logic             clear,
    output rx_pkt_t          rx_packet,
    output logic             rx_data_ready,
    output logic             rx_transfer_active,
    output logic             rx_error,
    output logic [CNT_W-1:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

    state_t  state;
    state_t  state_nxt;
    logic    pop_ok;
    logic    pop_req;
    logic    fwd;
    logic    status_reset;
    rx_pkt_t pkt_now;

    always_comb begin
        pop_ok    = !empty && (!buf_wvalid || buf_wready);
        pop_req   = 1'b0;
        state_nxt = state;
        pkt_now   = pid_to_pkt(PID);
        case (state)
            S_IDLE: begin
                if (rcving) state_nxt = S_ACTIVE;
            end
            S_ACTIVE, S_DRAIN: begin
                // A byte arriving with the counter already full is left in the FIFO for ERROR to discard
                if (r_error || (pop_ok && byte_count == CNT_MAX)) begin
                    state_nxt = S_ERROR;
                end else begin
                    pop_req = pop_ok;
                    if (state == S_ACTIVE && !rcving)
                        state_nxt = S_DRAIN;
                    else if (state == S_DRAIN && empty && !buf_wvalid)
                        state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rcving)     state_nxt = S_ACTIVE;
                else if (clear) state_nxt = S_IDLE;
            end
            S_ERROR: begin
                pop_req = !empty;
                if (clear && empty && !rcving) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        fwd          = pop_req && (state != S_ERROR);
        status_reset = (state_nxt == S_ACTIVE && state != S_ACTIVE) ||
                       (state_nxt == S_IDLE && state != S_IDLE);
    end

    // Held off during reset so the FIFO head is not consumed while state is being discarded
    assign r_enable = pop_req && n_rst;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state              <= S_IDLE;
            buf_wdata          <= 8'h00;
            buf_wvalid         <= 1'b0;
            rx_packet          <= NONE;
            rx_data_ready      <= 1'b0;
            rx_transfer_active <= 1'b0;
            rx_error           <= 1'b0;
            byte_count         <= '0;
        end else begin
            state              <= state_nxt;
            rx_error           <= (state_nxt == S_ERROR);
            rx_transfer_active <= (state_nxt == S_ACTIVE) || (state_nxt == S_DRAIN);

            if (fwd) begin
                buf_wdata  <= r_data;
                buf_wvalid <= 1'b1;
            end else if (buf_wready) begin
                buf_wvalid <= 1'b0;
            end

            if (status_reset) begin
                byte_count    <= '0;
                rx_packet     <= NONE;
                rx_data_ready <= 1'b0;
            end else if (state == S_DRAIN && state_nxt == S_DONE) begin
                rx_packet     <= pkt_now;
                rx_data_ready <= ((pkt_now == DATA0) || (pkt_now == DATA1)) && (byte_count != '0);
            end else if (fwd) begin
                byte_count <= byte_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_drain.sv
// tb/tb_usb_rx_drain.sv - self-checking bench for usb_rx_drain with FIFO model and byte scoreboard
module tb_usb_rx_drain;

    localparam int MAX_BYTES = 64;
    localparam int CNT_W     = 7;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             empty;
    logic [7:0]       r_data;
    logic             rcving;
    logic             r_error;
    logic [3:0]       PID;
    logic             r_enable;
    logic [7:0]       buf_wdata;
    logic             buf_wvalid;
    logic             buf_wready;
    logic             clear;
    logic [2:0]       rx_packet;
    logic             rx_data_ready;
    logic             rx_transfer_active;
    logic             rx_error;
    logic [CNT_W-1:0] byte_count;

    usb_rx_drain #(.MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .empty              (empty),
        .r_data             (r_data),
        .rcving             (rcving),
        .r_error            (r_error),
        .PID                (PID),
        .r_enable           (r_enable),
        .buf_wdata          (buf_wdata),
        .buf_wvalid         (buf_wvalid),
        .buf_wready         (buf_wready),
        .clear              (clear),
        .rx_packet          (rx_packet),
        .rx_data_ready      (rx_data_ready),
        .rx_transfer_active (rx_transfer_active),
        .rx_error           (rx_error),
        .byte_count         (byte_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // First-word-fall-through FIFO model feeding the DUT
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops   = 0;
    logic       pop_pend = 1'b0;
    logic [7:0] exp_q [$];

    assign empty  = (wr_ptr == rd_ptr);
    assign r_data = fifo_mem[rd_ptr[7:0]];

    always @(negedge clk) pop_pend = r_enable;

    always @(posedge clk) begin
        if (pop_pend) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    // Scoreboard: every accepted byte must be the oldest expected one
    always @(negedge clk) begin
        if (n_rst && buf_wvalid && buf_wready) begin
            check_val("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check_val("sb_data", buf_wdata, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic fwd);
        fifo_mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        if (fwd) exp_q.push_back(b);
    endtask

    task automatic wait_inactive(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (!rx_transfer_active) break;
            tick;
        end
        check_val({"inactive_", tag}, rx_transfer_active, 0);
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (empty && !buf_wvalid) break;
            tick;
        end
        check_val({"drained_", tag}, empty && !buf_wvalid, 1);
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    int p0;

    initial begin
        n_rst = 1'b0; rcving = 1'b0; r_error = 1'b0; PID = 4'b0000;
        buf_wready = 1'b1; clear = 1'b0;
        repeat (2) tick;
        check_val("rst_wvalid", buf_wvalid, 0);
        check_val("rst_wdata", buf_wdata, 8'h00);
        check_val("rst_packet", rx_packet, 0);
        check_val("rst_ready", rx_data_ready, 0);
        check_val("rst_active", rx_transfer_active, 0);
        check_val("rst_error", rx_error, 0);
        check_val("rst_count", byte_count, 0);
        check_val("rst_renable", r_enable, 0);
        n_rst = 1'b1;
        tick;

        // 1: DATA0 with three bytes, ready always high
        p0 = pops;
        PID = 4'b0011;
        push_byte(8'hA5, 1'b1); push_byte(8'h5A, 1'b1); push_byte(8'hFF, 1'b1);
        rcving = 1'b1;
        tick;
        check_val("t1_active", rx_transfer_active, 1);
        repeat (4) tick;
        rcving = 1'b0;
        tick;
        wait_inactive("t1");
        check_val("t1_packet", rx_packet, 3);
        check_val("t1_count", byte_count, 3);
        check_val("t1_ready", rx_data_ready, 1);
        check_val("t1_error", rx_error, 0);
        check_val("t1_pops", pops - p0, 3);
        check_val("t1_sb_left", exp_q.size(), 0);
        pulse_clear;
        check_val("t1_clr_count", byte_count, 0);
        check_val("t1_clr_packet", rx_packet, 0);

        // 2: ACK without payload
        p0 = pops;
        PID = 4'b0010;
        rcving = 1'b1;
        repeat (2) tick;
        rcving = 1'b0;
        tick;
        wait_inactive("t2");
        check_val("t2_pops", pops - p0, 0);
        check_val("t2_packet", rx_packet, 5);
        check_val("t2_ready", rx_data_ready, 0);
        check_val("t2_count", byte_count, 0);
        pulse_clear;
        check_val("t2_clr_packet", rx_packet, 0);
        check_val("t2_clr_ready", rx_data_ready, 0);
        check_val("t2_clr_error", rx_error, 0);
        check_val("t2_clr_count", byte_count, 0);

        // 3: backpressure holds the output byte and stops popping
        p0 = pops;
        PID = 4'b0011;
        push_byte(8'h11, 1'b1); push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1); push_byte(8'h44, 1'b1);
        buf_wready = 1'b0;
        rcving = 1'b1;
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            check_val("t3_hold_valid", buf_wvalid, 1);
            check_val("t3_hold_data", buf_wdata, 8'h11);
            check_val("t3_no_pop", r_enable, 0);
            tick;
        end
        buf_wready = 1'b1;
        rcving = 1'b0;
        tick;
        wait_inactive("t3");
        check_val("t3_pops", pops - p0, 4);
        check_val("t3_count", byte_count, 4);
        check_val("t3_sb_left", exp_q.size(), 0);
        pulse_clear;

        // 4: DATA1 overflow at MAX_BYTES+1
        p0 = pops;
        PID = 4'b1011;
        for (int i = 0; i < MAX_BYTES; i++) push_byte(8'(i * 3 + 1), 1'b1);
        push_byte(8'hEE, 1'b0);
        rcving = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (rx_error) break;
            tick;
        end
        check_val("t4_error", rx_error, 1);
        wait_drained("t4");
        check_val("t4_count", byte_count, MAX_BYTES);
        check_val("t4_pops", pops - p0, MAX_BYTES + 1);
        check_val("t4_sb_left", exp_q.size(), 0);
        check_val("t4_active", rx_transfer_active, 0);
        rcving = 1'b0;
        pulse_clear;
        check_val("t4_clr_error", rx_error, 0);

        // 5: receiver error after two bytes, stray bytes discarded
        p0 = pops;
        PID = 4'b0011;
        push_byte(8'hC1, 1'b1); push_byte(8'hC2, 1'b1);
        rcving = 1'b1;
        tick;
        wait_drained("t5_pre");
        r_error = 1'b1;
        tick;
        r_error = 1'b0;
        check_val("t5_error", rx_error, 1);
        push_byte(8'hD1, 1'b0); push_byte(8'hD2, 1'b0); push_byte(8'hD3, 1'b0);
        pulse_clear;
        check_val("t5_clr_ignored", rx_error, 1);
        wait_drained("t5");
        rcving = 1'b0;
        tick;
        check_val("t5_still_err", rx_error, 1);
        pulse_clear;
        check_val("t5_clr_error", rx_error, 0);
        check_val("t5_clr_active", rx_transfer_active, 0);
        check_val("t5_pops", pops - p0, 5);

        // 6: reset mid-packet with a pending output byte
        PID = 4'b0011;
        buf_wready = 1'b0;
        push_byte(8'h77, 1'b1);
        rcving = 1'b1;
        tick;
        tick;
        check_val("t6_pending", buf_wvalid, 1);
        n_rst = 1'b0;
        exp_q.delete();
        tick;
        check_val("t6_rst_wvalid", buf_wvalid, 0);
        check_val("t6_rst_wdata", buf_wdata, 8'h00);
        check_val("t6_rst_active", rx_transfer_active, 0);
        check_val("t6_rst_count", byte_count, 0);
        check_val("t6_rst_error", rx_error, 0);
        n_rst = 1'b1;
        rcving = 1'b0;
        buf_wready = 1'b1;
        tick;

        // 6b: rcving beats clear in DONE
        PID = 4'b0010;
        rcving = 1'b1;
        tick;
        rcving = 1'b0;
        tick;
        wait_inactive("t6b");
        check_val("t6b_packet", rx_packet, 5);
        clear = 1'b1;
        rcving = 1'b1;
        tick;
        clear = 1'b0;
        check_val("t6b_restart", rx_transfer_active, 1);
        check_val("t6b_packet_rst", rx_packet, 0);
        rcving = 1'b0;
        tick;
        wait_inactive("t6b_end");
        check_val("t6b_packet_end", rx_packet, 5);

        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
